// File: rtl/fpga_utility_pkg.sv
// fpga_utility_pkg -- shared helpers for the small FPGA utility blocks.
//
// count_width(depth): width of an occupancy counter that must hold every
// value from 0 up to and including depth.
package fpga_utility_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/shift_register_dynamic.sv
// shift_register_dynamic -- push-only shift array with a dynamic read tap,
// written so synthesis maps it onto SRL16/SRL32 primitives.
//
// Parameters:
//   DATA_WIDTH          width of each entry
//   DEPTH               number of entries (power of two)
//   NUM_REGISTER_OUTPUT pipeline registers after the read mux (0 = combinational)
// Ports:
//   clk    in   clock
//   wea    in   shift enable: sr[0] <= dia, sr[i] <= sr[i-1]
//   dia    in   DATA_WIDTH  data shifted into sr[0]
//   addrb  in   $clog2(DEPTH) read tap
//   dob    out  DATA_WIDTH  sr[addrb], delayed by NUM_REGISTER_OUTPUT clocks
module shift_register_dynamic #(
  parameter int DATA_WIDTH          = 8,
  parameter int DEPTH               = 16,
  parameter int NUM_REGISTER_OUTPUT = 0
) (
  input  logic                     clk,
  input  logic                     wea,
  input  logic [DATA_WIDTH-1:0]    dia,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    dob
);

  // No reset on the array: SRL primitives have none, and a reset would
  // force the tools into plain flip-flops.
  logic [DATA_WIDTH-1:0] sr [DEPTH];
  logic [DATA_WIDTH-1:0] tap;

  always_ff @(posedge clk) begin
    if (wea) begin
      sr[0] <= dia;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tap = sr[addrb];

  generate
    if (NUM_REGISTER_OUTPUT == 0) begin : g_comb_out
      assign dob = tap;
    end else begin : g_reg_out
      logic [DATA_WIDTH-1:0] pipe [NUM_REGISTER_OUTPUT];
      always_ff @(posedge clk) begin
        pipe[0] <= tap;
        for (int i = 1; i < NUM_REGISTER_OUTPUT; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
      assign dob = pipe[NUM_REGISTER_OUTPUT-1];
    end
  endgenerate

endmodule

// File: rtl/srl_fifo.sv
// srl_fifo -- first-word-fall-through FIFO on SRL shift-register storage.
//
// Writes shift into the front of the array; the oldest word sits at
// sr[sc-1], so the read tap is driven from the occupancy counter.
//
// Build option: define SRL_FIFO_OUTPUT_REG_EN to add a head register after
// the read mux (capacity DEPTH+1, 2-cycle push-to-valid latency, no
// combinational path from the array to out_data).
//
// Parameters:
//   DATA_WIDTH  entry width
//   DEPTH       shift-array depth, power of two, 2..64
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   write request
//   in_ready   out  FIFO can accept a word (registered)
//   in_data    in   DATA_WIDTH write data
//   out_valid  out  head word present (registered)
//   out_ready  in   consumer accepts head
//   out_data   out  DATA_WIDTH head word
//   count      out  $clog2(DEPTH)+1 total words held (registered)
module srl_fifo
  import fpga_utility_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [CW-1:0]         sc;
  logic [CW-1:0]         sc_next;
  logic                  push;
  logic                  pop;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // in_ready is registered, so a full FIFO refuses a push even while popping.
  assign push = in_valid & in_ready;

  // Oldest word is at sc-1. With a simultaneous push and pop the address is
  // unchanged and, after the shift, selects the next-oldest word.
  assign rd_addr = AW'(sc - CW'(1));

  shift_register_dynamic #(
    .DATA_WIDTH          (DATA_WIDTH),
    .DEPTH               (DEPTH),
    .NUM_REGISTER_OUTPUT (0)
  ) u_sr (
    .clk   (clk),
    .wea   (push),
    .dia   (in_data),
    .addrb (rd_addr),
    .dob   (rd_data)
  );

`ifdef SRL_FIFO_OUTPUT_REG_EN

  logic                  head_valid;
  logic                  head_valid_next;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  arr_pop;

  assign pop = head_valid & out_ready;

  // Refill the head whenever it is empty or leaving and the array has a
  // word; that refill is what removes a word from the array.
  assign arr_pop = (sc != '0) && (!head_valid || pop);

  always_comb begin
    sc_next         = sc;
    head_valid_next = head_valid;
    if (push && !arr_pop) begin
      sc_next = sc + CW'(1);
    end else if (!push && arr_pop) begin
      sc_next = sc - CW'(1);
    end
    if (arr_pop) begin
      head_valid_next = 1'b1;
    end else if (pop) begin
      head_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc         <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
      in_ready   <= 1'b0;
      count      <= '0;
    end else begin
      sc         <= sc_next;
      head_valid <= head_valid_next;
      if (arr_pop) begin
        head_data <= rd_data;
      end
      in_ready   <= (sc_next != CW'(DEPTH));
      count      <= sc_next + CW'(head_valid_next);
    end
  end

  assign out_valid = head_valid;
  assign out_data  = head_data;

`else

  logic valid_q;

  assign pop = valid_q & out_ready;

  always_comb begin
    sc_next = sc;
    if (push && !pop) begin
      sc_next = sc + CW'(1);
    end else if (!push && pop) begin
      sc_next = sc - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc       <= '0;
      valid_q  <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      sc       <= sc_next;
      valid_q  <= (sc_next != '0);
      in_ready <= (sc_next != CW'(DEPTH));
    end
  end

  assign out_valid = valid_q;
  assign out_data  = rd_data;
  assign count     = sc;

`endif

endmodule

// File: tb/tb_srl_fifo.sv
module tb_srl_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SRL_FIFO_OUTPUT_REG_EN
  localparam int CAP      = DEPTH + 1;
  localparam int VLD_EDGE1 = 0;  // out_valid right after the push edge
`else
  localparam int CAP      = DEPTH;
  localparam int VLD_EDGE1 = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  srl_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard queue ----------------
  logic [DW-1:0] exp_q[$];
  int m_sc = 0;
  int m_head = 0;
  int m_in_ready = 0;
  int n_pushed = 0;

  function automatic int m_out_valid();
`ifdef SRL_FIFO_OUTPUT_REG_EN
    return m_head;
`else
    return (m_sc != 0) ? 1 : 0;
`endif
  endfunction

  function automatic int m_count();
    return m_sc + m_head;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int mpush, mpop, arr;
    if (!reset_n) begin
      m_sc = 0; m_head = 0; m_in_ready = 0;
      exp_q.delete();
    end else begin
      mpush = (in_valid && m_in_ready != 0) ? 1 : 0;
      mpop  = (m_out_valid() != 0 && out_ready) ? 1 : 0;
      if (mpush != 0) begin
        exp_q.push_back(in_data);
        n_pushed++;
      end
`ifdef SRL_FIFO_OUTPUT_REG_EN
      arr = (m_sc != 0 && (m_head == 0 || mpop != 0)) ? 1 : 0;
      m_sc = m_sc + mpush - arr;
      if (arr != 0) m_head = 1;
      else if (mpop != 0) m_head = 0;
`else
      arr = 0;
      m_sc = m_sc + mpush - mpop;
`endif
      m_in_ready = (m_sc != DEPTH) ? 1 : 0;
    end
  end

  // ---------------- monitor: flags and popped data ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    check("mon_count", int'(count), m_count());
    check("mon_in_ready", int'(in_ready), m_in_ready);
    check("mon_out_valid", int'(out_valid), m_out_valid());
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_underflow: got 0x%0h expected no word", out_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", int'(out_data), int'(e));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int cyc;

    // Reset held with clock running and in_valid asserted.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_count", int'(count), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", int'(in_ready), 0);
    step();
    check("rel_in_ready_after_edge", int'(in_ready), 1);

    // Fill to capacity, then a refused extra push.
    for (int i = 1; i <= CAP; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
    end
    in_valid = 1'b0;
    check("fill_count", int'(count), CAP);
    check("fill_in_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    in_valid = 1'b0;
    check("refused_push_count", int'(count), CAP);
    check("fill_head", int'(out_data), 8'h01);
    out_ready = 1'b1;
    for (int i = 0; i < CAP; i++) step();
    out_ready = 1'b0;
    check("drain_out_valid", int'(out_valid), 0);
    check("drain_count", int'(count), 0);

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'hA1 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("pp_count_before", int'(count), 3);
    check("pp_head_before", int'(out_data), 8'hA1);
    in_valid  = 1'b1;
    in_data   = 8'hA4;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_count_after", int'(count), 3);
    check("pp_head_after", int'(out_data), 8'hA2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    check("pp_drained", int'(count), 0);

    // Full with pop: pop accepted, push refused, push taken next cycle.
    for (int i = 0; i < CAP; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'h30 + i);
      step();
    end
    check("fp_full_count", int'(count), CAP);
    in_data   = 8'h5F;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("fp_count_after_pop", int'(count), CAP - 1);
    check("fp_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("fp_count_after_push", int'(count), CAP);
    out_ready = 1'b1;
    for (int i = 0; i < CAP; i++) step();
    out_ready = 1'b0;
    check("fp_drained", int'(count), 0);

    // Single word latency.
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    check("lat_valid_edge1", int'(out_valid), VLD_EDGE1);
    step();
    check("lat_valid_edge2", int'(out_valid), 1);
    check("lat_data", int'(out_data), 8'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-stream at count 7.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    check("mid_count_before", int'(count), 7);
    #1 reset_n = 1'b0;
    #1;
    check("mid_async_count", int'(count), 0);
    check("mid_async_out_valid", int'(out_valid), 0);
    #1 reset_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    step();
    in_valid = 1'b0;
    step();
    check("mid_after_valid", int'(out_valid), 1);
    check("mid_after_data", int'(out_data), 8'hAA);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mid_no_stale", int'(out_valid), 0);

    // Random streaming of 100 words against the scoreboard.
    n_pushed = 0;
    cyc = 0;
    while (n_pushed < 100 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 1) != 0);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_pushed", n_pushed, 100);
    out_ready = 1'b1;
    cyc = 0;
    while (m_count() != 0 && cyc < 200) begin
      step();
      cyc++;
    end
    out_ready = 1'b0;
    step();
    check("stream_final_count", int'(count), 0);
    check("stream_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
